lsu_mem_slave: RTL and testbench

LSU_MEM_SLAVE -- requirements
Module: lsu_mem_slave

---
 rtl/lsu_mem_slave.sv | 128 ++++++++++++
 tb/tb_lsu_mem_slave.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_slave.sv
// Word-addressed SRAM slave for the LSU: byte-lane writes, registered reads,
// programmable wait states and a one-cycle ack/err handshake.
module lsu_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_dat_i,
  input  logic [3:0]  lsu_sel_i,
  input  logic        lsu_we_i,
  input  logic        lsu_re_i,
  output logic [31:0] lsu_dat_o,
  output logic        lsu_ack_o,
  output logic        lsu_err_o
);

  localparam int unsigned AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  WS   = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic        wr_q, wr_n;
  logic        err_q, err_n;
  logic        commit;
  logic        commit_wr, commit_rd;
  logic        req;
  logic        in_range;
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic [31:0] dat_q;

  logic [31:0] mem [DEPTH_WORDS];

  assign req      = lsu_we_i | lsu_re_i;
  assign offset   = lsu_addr_i - BASE_ADDR;
  // 33-bit compare so a 4 GiB window does not overflow the span constant
  assign in_range = {1'b0, offset} < SPAN;
  assign idx      = offset[AW+1:2];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      cnt   <= '0;
      wr_q  <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      wr_q  <= wr_n;
      err_q <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    wr_n    = wr_q;
    err_n   = err_q;
    commit  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req) begin
          wr_n  = lsu_we_i;
          err_n = ~in_range;
          if (!in_range || WS == 4'd0) begin
            state_n = S_RESP;
            commit  = in_range;
          end else begin
            state_n = S_WAIT;
            cnt_n   = WS - 4'd1;
          end
        end
      end
      S_WAIT: begin
        // Requester withdrawing both strobes aborts the pending access
        if (!req) begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end else if (cnt == 4'd0) begin
          state_n = S_RESP;
          commit  = 1'b1;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    lsu_ack_o = 1'b0;
    lsu_err_o = 1'b0;
    if (state == S_RESP) begin
      lsu_ack_o = ~err_q;
      lsu_err_o = err_q;
    end
  end

  assign commit_wr = commit & wr_n & ~rst_i;
  assign commit_rd = commit & ~wr_n;

  always_ff @(posedge clk_i) begin
    if (commit_wr) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lsu_sel_i[i]) mem[idx][8*i +: 8] <= lsu_dat_i[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) dat_q <= '0;
    else if (commit_rd) dat_q <= mem[idx];
  end

  assign lsu_dat_o = dat_q;

endmodule

// File: tb/tb_lsu_mem_slave.sv
// Directed bench for lsu_mem_slave: three instances cover 1, 3 and 0 wait states.
module tb_lsu_mem_slave;

  logic        clk = 1'b0;
  logic        rst  [3];
  logic [31:0] addr [3];
  logic [31:0] wdat [3];
  logic [3:0]  sel  [3];
  logic        we   [3];
  logic        re   [3];
  logic [31:0] rdat [3];
  logic        ack  [3];
  logic        err  [3];

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  lsu_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(1)) u_ws1 (
    .clk_i(clk), .rst_i(rst[0]), .lsu_addr_i(addr[0]), .lsu_dat_i(wdat[0]),
    .lsu_sel_i(sel[0]), .lsu_we_i(we[0]), .lsu_re_i(re[0]),
    .lsu_dat_o(rdat[0]), .lsu_ack_o(ack[0]), .lsu_err_o(err[0]));

  lsu_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
    .clk_i(clk), .rst_i(rst[1]), .lsu_addr_i(addr[1]), .lsu_dat_i(wdat[1]),
    .lsu_sel_i(sel[1]), .lsu_we_i(we[1]), .lsu_re_i(re[1]),
    .lsu_dat_o(rdat[1]), .lsu_ack_o(ack[1]), .lsu_err_o(err[1]));

  lsu_mem_slave #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
    .clk_i(clk), .rst_i(rst[2]), .lsu_addr_i(addr[2]), .lsu_dat_i(wdat[2]),
    .lsu_sel_i(sel[2]), .lsu_we_i(we[2]), .lsu_re_i(re[2]),
    .lsu_dat_o(rdat[2]), .lsu_ack_o(ack[2]), .lsu_err_o(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request now and counts posedges until ack or err shows up.
  task automatic access(input int d, input logic w, input logic r,
                        input logic [31:0] a, input logic [31:0] dat, input logic [3:0] s,
                        input int exp_n, input logic exp_err, input logic idle_after,
                        input string tag);
    int   n;
    logic seen_ack, seen_err;
    n = 0; seen_ack = 1'b0; seen_err = 1'b0;
    addr[d] = a; wdat[d] = dat; sel[d] = s; we[d] = w; re[d] = r;
    while (n < 20 && !seen_ack && !seen_err) begin
      @(posedge clk); #1;
      n++;
      seen_ack = ack[d];
      seen_err = err[d];
    end
    check({tag, " latency"}, n, exp_n);
    check({tag, " ack"}, {31'b0, seen_ack}, {31'b0, ~exp_err});
    check({tag, " err"}, {31'b0, seen_err}, {31'b0, exp_err});
    @(negedge clk);
    we[d] = 1'b0; re[d] = 1'b0;
    if (idle_after) begin
      @(posedge clk); #1;
      check({tag, " pulse width"}, {30'b0, ack[d], err[d]}, 32'h0);
      @(negedge clk);
    end
  endtask

  task automatic watch(input int d, input int cycles, output logic any);
    any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      any = any | ack[d] | err[d];
    end
  endtask

  initial begin
    logic quiet;
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; addr[i] = '0; wdat[i] = '0; sel[i] = '0; we[i] = 1'b0; re[i] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("reset dat", rdat[i], 32'h0);
      check("reset ack/err", {30'b0, ack[i], err[i]}, 32'h0);
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) rst[i] = 1'b0;

    // Full-word write then read, one wait state
    access(0, 1, 0, 32'h10, 32'hDEADBEEF, 4'hF, 2, 0, 1, "wr 0x10");
    access(0, 0, 1, 32'h10, 32'h0, 4'hF, 2, 0, 1, "rd 0x10");
    check("rd 0x10 data", rdat[0], 32'hDEADBEEF);

    // Range boundaries: last word in range, first word out, wrapped address
    access(0, 1, 0, 32'hFFC, 32'hCAFEF00D, 4'hF, 2, 0, 1, "wr 0xffc");
    access(0, 0, 1, 32'h1000, 32'h0, 4'hF, 1, 1, 1, "rd 0x1000");
    check("err keeps dat", rdat[0], 32'hDEADBEEF);
    access(0, 1, 0, 32'hFFFFFFFC, 32'h12345678, 4'hF, 1, 1, 1, "wr 0xfffffffc");
    access(0, 0, 1, 32'hFFC, 32'h0, 4'hF, 2, 0, 1, "rd 0xffc");
    check("rd 0xffc data", rdat[0], 32'hCAFEF00D);

    // Byte lanes
    access(0, 1, 0, 32'h10, 32'h0, 4'hF, 2, 0, 1, "clr 0x10");
    access(0, 1, 0, 32'h10, 32'hABABABAB, 4'b0100, 2, 0, 1, "wr lane2");
    access(0, 0, 1, 32'h10, 32'h0, 4'b0000, 2, 0, 1, "rd lane2");
    check("lane2 data", rdat[0], 32'h00AB0000);
    access(0, 1, 0, 32'h10, 32'h12341234, 4'b0011, 2, 0, 1, "wr lane10");
    access(0, 0, 1, 32'h10, 32'h0, 4'hF, 2, 0, 1, "rd lane10");
    check("lane10 data", rdat[0], 32'h00AB1234);

    // we and re together is a write; zero-sel write acks without changing data
    access(0, 1, 1, 32'h30, 32'h77, 4'hF, 2, 0, 1, "we+re 0x30");
    check("we+re keeps dat", rdat[0], 32'h00AB1234);
    access(0, 1, 0, 32'h30, 32'hFFFFFFFF, 4'h0, 2, 0, 1, "sel0 wr 0x30");
    access(0, 0, 1, 32'h30, 32'h0, 4'hF, 2, 0, 1, "rd 0x30");
    check("0x30 data", rdat[0], 32'h00000077);

    // Three wait states: abort by dropping we, then abort by reset
    access(1, 1, 0, 32'h20, 32'h11111111, 4'hF, 4, 0, 1, "ws3 preload");
    access(1, 0, 1, 32'h20, 32'h0, 4'hF, 4, 0, 1, "ws3 rd");
    check("ws3 preload data", rdat[1], 32'h11111111);

    addr[1] = 32'h20; wdat[1] = 32'h5; sel[1] = 4'hF; we[1] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    we[1] = 1'b0;
    watch(1, 6, quiet);
    check("abort no resp", {31'b0, quiet}, 32'h0);
    access(1, 0, 1, 32'h20, 32'h0, 4'hF, 4, 0, 1, "rd after abort");
    check("abort word kept", rdat[1], 32'h11111111);

    addr[1] = 32'h20; wdat[1] = 32'h5; sel[1] = 4'hF; we[1] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b1;
    @(posedge clk); #1;
    check("rst in wait dat", rdat[1], 32'h0);
    check("rst in wait ack", {31'b0, ack[1]}, 32'h0);
    @(negedge clk);
    rst[1] = 1'b0; we[1] = 1'b0;
    watch(1, 6, quiet);
    check("rst abort no resp", {31'b0, quiet}, 32'h0);
    access(1, 0, 1, 32'h20, 32'h0, 4'hF, 4, 0, 1, "rd after rst");
    check("mem kept over rst", rdat[1], 32'h11111111);

    // Zero wait states, back-to-back reads held until ack
    access(2, 1, 0, 32'h0, 32'h0A0A0A0A, 4'hF, 1, 0, 1, "ws0 wr 0x0");
    access(2, 1, 0, 32'h4, 32'h0B0B0B0B, 4'hF, 1, 0, 1, "ws0 wr 0x4");
    access(2, 1, 0, 32'h8, 32'h0C0C0C0C, 4'hF, 1, 0, 1, "ws0 wr 0x8");
    access(2, 0, 1, 32'h0, 32'h0, 4'hF, 1, 0, 0, "b2b rd 0x0");
    check("b2b 0x0 data", rdat[2], 32'h0A0A0A0A);
    access(2, 0, 1, 32'h4, 32'h0, 4'hF, 2, 0, 0, "b2b rd 0x4");
    check("b2b 0x4 data", rdat[2], 32'h0B0B0B0B);
    access(2, 0, 1, 32'h8, 32'h0, 4'hF, 2, 0, 1, "b2b rd 0x8");
    check("b2b 0x8 data", rdat[2], 32'h0C0C0C0C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
